cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle controller for the single-issue ARM-style datapath: RAM, decoder, register bank, barrel shifter and ALU.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Owns the PC, instruction register and CNZV flag register, and shares the single RAM port between instruction fetch and load/store.
- Evaluates condition codes and generates all RAM and register-bank write strobes.

Parameters:
PC_WIDTH, 14, width of PC and RAM address
WORD_WIDTH, 32, datapath and instruction width (matches `WordWidth)
PC_STEP, 4, PC increment per instruction (byte addressing)

Ports:
clock  input  1  system clock, all state on rising edge
nreset  input  1  synchronous reset, active-high (1 = reset)
i_Stall  input  1  freeze sequencer this cycle
i_Instruction  input  32  RAM read data, valid the cycle after the address is presented
i_Instruction_type  input  4  decoder type of o_Instr_reg
i_Set_cond  input  1  decoder S bit (DP) / L bit (LDST: 1=load; BRANCH: 1=link)
i_Byte  input  1  LDST byte access
i_Alu_CNZV  input  4  ALU result flags
i_Alu_writeback  input  1  ALU says result is written (0 for TST/TEQ/CMP/CMN)
i_Mem_addr  input  14  load/store address from ALU
i_Branch_target  input  14  branch destination from ALU
o_Pc  output  14  program counter
o_Instr_reg  output  32  latched instruction, feeds decoder
o_CNZV  output  4  current flags, feeds shifter carry-in and condition check
o_Ram_Addr  output  14  RAM address
o_Ram_Write_enable  output  1  RAM write strobe
o_Ram_Size  output  2  00 byte, 10 word
o_Reg_write_enable  output  1  register-bank write strobe
o_Wb_sel  output  2  0 ALU result, 1 RAM data, 2 link value (o_Pc+4)
o_Halted  output  1  sequencer in HALT
o_State  output  3  current state (debug)

Behaviour:
- Reset, checked first and overriding stall: o_Pc=0, state=FETCH, o_Instr_reg=0, o_CNZV=0, o_Halted=0, o_Ram_Size=2'b10, all strobes 0, o_Wb_sel=0.
- Outputs are Moore decodes of state and registers, except o_Ram_Addr and o_Ram_Size in MEMORY/WRITEBACK, which follow i_Mem_addr and i_Byte.
- RAM samples the address at the rising edge; data returns the next cycle.
- FETCH: o_Ram_Addr=o_Pc. Next state DECODE.
- DECODE: o_Ram_Addr=o_Pc. Latch i_Instruction into o_Instr_reg. Next state EXECUTE.
- EXECUTE: cond_check compares o_Instr_reg[31:28] with o_CNZV.
  - Condition fails: o_Pc+=4, go to FETCH. No flag, register or RAM effect.
  - Condition passes, type DP or MUL: go to WRITEBACK. If i_Set_cond, load o_CNZV from i_Alu_CNZV at end of EXECUTE.
  - Condition passes, type LDST: go to MEMORY.
  - Condition passes, type BRANCH: o_Pc=i_Branch_target with bits[1:0] forced to 0. If link, o_Reg_write_enable=1 and o_Wb_sel=2 this cycle (value is the pre-branch o_Pc+4). Go to FETCH.
  - Condition passes, type SWI or UNDEF: go to HALT.
- MEMORY: o_Ram_Addr=i_Mem_addr; o_Ram_Size = 00 if i_Byte else 10.
  - Store: o_Ram_Write_enable=1 for exactly this cycle, o_Pc+=4, go to FETCH.
  - Load: go to WRITEBACK.
- WRITEBACK: o_Pc+=4, go to FETCH.
  - DP/MUL: o_Reg_write_enable=i_Alu_writeback, o_Wb_sel=0.
  - Load: o_Ram_Addr still = i_Mem_addr, o_Reg_write_enable=1, o_Wb_sel=1 (RAM data now valid).
- HALT: o_Halted=1, all strobes 0; stays in HALT until reset.
- Latency in cycles: DP/MUL 4, load 5, store 4, branch 3, condition-fail 3.
- Stall: while i_Stall=1, state, PC, instruction register and flags all hold, and both write strobes are forced to 0. The suppressed write re-issues when the stall releases, so each store/writeback occurs exactly once.
- PC arithmetic is modulo 2^14: 0x3FFC+4 = 0x0000.
- Reset asserted mid-instruction aborts it; no strobe is asserted in the reset cycle.

Decomposition:
- Shared header (Def_StructureParameter.v):
  - State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
  - Instruction-type codes: DP, MUL, LDST, BRANCH, SWI, UNDEF.
  - Condition-field codes EQ through AL.
  - o_Wb_sel codes.
- Sub-module cond_check: combinational, cond[3:0] + CNZV[3:0] -> pass.

Test Plan:
- Reset, then DP ADD with S, result 0 at PC 0 -> states F,D,E,WB; flags Z=1 at end of EXECUTE; one o_Reg_write_enable pulse with o_Wb_sel=0; o_Pc=4 after 4 cycles.
- LDR word from 0x0100 at PC 0x0010 -> MEMORY cycle shows o_Ram_Addr=0x0100, size 10; WRITEBACK write pulse with o_Wb_sel=1; o_Pc=0x0014; 5 cycles total.
- STRB to 0x0203 with i_Stall high for 2 cycles in MEMORY -> o_Ram_Write_enable=0 during stall, then exactly one pulse with size 00 and o_Ram_Addr=0x0203.
- BEQ with Z=0 then Z=1, target 0x0043 -> first: PC+4, 3 cycles, no writes; second: o_Pc=0x0040; BL variant gives a write pulse with o_Wb_sel=2.
- NOP at PC 0x3FFC -> o_Pc wraps to 0x0000; CMP -> flags update, o_Reg_write_enable stays 0.
- SWI -> o_Halted=1, PC frozen for 20 cycles; reset asserted -> FETCH at PC 0 next cycle; reset during a MEMORY store -> no write strobe.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, decoder types,
// condition fields, flag bit positions, write-back selects and RAM sizes.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    T_DP     = 4'd0,
    T_MUL    = 4'd1,
    T_LDST   = 4'd2,
    T_BRANCH = 4'd3,
    T_SWI    = 4'd4,
    T_UNDEF  = 4'd5
  } itype_t;

  typedef enum logic [3:0] {
    C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_CC = 4'd3,
    C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
    C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
    C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14
  } cond_t;

  // Bit positions inside the CNZV vector
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_RAM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/cpu_sequencer_cond_check.sv
// Combinational condition-code evaluation against the CNZV flags.
module cpu_sequencer_cond_check
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cnzv,
  output logic       pass
);

  logic c, n, z, v;
  assign c = cnzv[FLAG_C];
  assign n = cnzv[FLAG_N];
  assign z = cnzv[FLAG_Z];
  assign v = cnzv[FLAG_V];

  // Encoding 4'hF (NV) never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      C_EQ:    pass = z;
      C_NE:    pass = !z;
      C_CS:    pass = c;
      C_CC:    pass = !c;
      C_MI:    pass = n;
      C_PL:    pass = !n;
      C_VS:    pass = v;
      C_VC:    pass = !v;
      C_HI:    pass = c && !z;
      C_LS:    pass = !c || z;
      C_GE:    pass = (n == v);
      C_LT:    pass = (n != v);
      C_GT:    pass = !z && (n == v);
      C_LE:    pass = z || (n != v);
      C_AL:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller owning PC,
// instruction register and flags, and arbitrating the single RAM port.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_WIDTH   = 14,
  parameter int WORD_WIDTH = 32,
  parameter int PC_STEP    = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  i_Stall,
  input  logic [WORD_WIDTH-1:0] i_Instruction,
  input  logic [3:0]            i_Instruction_type,
  input  logic                  i_Set_cond,
  input  logic                  i_Byte,
  input  logic [3:0]            i_Alu_CNZV,
  input  logic                  i_Alu_writeback,
  input  logic [PC_WIDTH-1:0]   i_Mem_addr,
  input  logic [PC_WIDTH-1:0]   i_Branch_target,
  output logic [PC_WIDTH-1:0]   o_Pc,
  output logic [WORD_WIDTH-1:0] o_Instr_reg,
  output logic [3:0]            o_CNZV,
  output logic [PC_WIDTH-1:0]   o_Ram_Addr,
  output logic                  o_Ram_Write_enable,
  output logic [1:0]            o_Ram_Size,
  output logic                  o_Reg_write_enable,
  output logic [1:0]            o_Wb_sel,
  output logic                  o_Halted,
  output logic [2:0]            o_State
);

  localparam logic [PC_WIDTH-1:0] STEP  = PC_STEP[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] ALIGN = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  state_t state;
  logic   pass;
  logic   write_ok;

  cpu_sequencer_cond_check u_cond_check (
    .cond (o_Instr_reg[WORD_WIDTH-1 -: 4]),
    .cnzv (o_CNZV),
    .pass (pass)
  );

  // Stall and the reset cycle both suppress every write strobe
  assign write_ok = !i_Stall && !nreset;
  assign o_State  = state;
  assign o_Halted = (state == S_HALT);

  // Sequencer state, PC, instruction register and flag register
  always_ff @(posedge clock) begin
    if (nreset) begin
      state       <= S_FETCH;
      o_Pc        <= {PC_WIDTH{1'b0}};
      o_Instr_reg <= {WORD_WIDTH{1'b0}};
      o_CNZV      <= 4'b0000;
    end else if (!i_Stall) begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          o_Instr_reg <= i_Instruction;
          state       <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (!pass) begin
            o_Pc  <= o_Pc + STEP;
            state <= S_FETCH;
          end else begin
            case (i_Instruction_type)
              T_DP, T_MUL: begin
                if (i_Set_cond) o_CNZV <= i_Alu_CNZV;
                state <= S_WRITEBACK;
              end
              T_LDST: state <= S_MEMORY;
              T_BRANCH: begin
                o_Pc  <= i_Branch_target & ALIGN;
                state <= S_FETCH;
              end
              default: state <= S_HALT;
            endcase
          end
        end
        S_MEMORY: begin
          if (i_Set_cond) begin
            state <= S_WRITEBACK;
          end else begin
            o_Pc  <= o_Pc + STEP;
            state <= S_FETCH;
          end
        end
        S_WRITEBACK: begin
          o_Pc  <= o_Pc + STEP;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // RAM port and register-bank control decoded from the current state
  always_comb begin
    o_Ram_Addr         = o_Pc;
    o_Ram_Size         = SIZE_WORD;
    o_Ram_Write_enable = 1'b0;
    o_Reg_write_enable = 1'b0;
    o_Wb_sel           = WB_ALU;
    case (state)
      S_EXECUTE: begin
        if (pass && (i_Instruction_type == T_BRANCH) && i_Set_cond) begin
          o_Reg_write_enable = write_ok;
          o_Wb_sel           = WB_LINK;
        end else begin
          o_Wb_sel = WB_ALU;
        end
      end
      S_MEMORY: begin
        o_Ram_Addr         = i_Mem_addr;
        o_Ram_Size         = i_Byte ? SIZE_BYTE : SIZE_WORD;
        o_Ram_Write_enable = !i_Set_cond && write_ok;
      end
      S_WRITEBACK: begin
        o_Ram_Addr = i_Mem_addr;
        o_Ram_Size = i_Byte ? SIZE_BYTE : SIZE_WORD;
        if (i_Instruction_type == T_LDST) begin
          o_Reg_write_enable = write_ok;
          o_Wb_sel           = WB_RAM;
        end else begin
          o_Reg_write_enable = i_Alu_writeback && write_ok;
        end
      end
      default: o_Ram_Addr = o_Pc;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the bench plays decoder and ALU by
// driving hand-chosen type/flag/address values for each instruction.
module tb_cpu_sequencer;

  logic        clock;
  logic        nreset;
  logic        i_Stall;
  logic [31:0] i_Instruction;
  logic [3:0]  i_Instruction_type;
  logic        i_Set_cond;
  logic        i_Byte;
  logic [3:0]  i_Alu_CNZV;
  logic        i_Alu_writeback;
  logic [13:0] i_Mem_addr;
  logic [13:0] i_Branch_target;
  logic [13:0] o_Pc;
  logic [31:0] o_Instr_reg;
  logic [3:0]  o_CNZV;
  logic [13:0] o_Ram_Addr;
  logic        o_Ram_Write_enable;
  logic [1:0]  o_Ram_Size;
  logic        o_Reg_write_enable;
  logic [1:0]  o_Wb_sel;
  logic        o_Halted;
  logic [2:0]  o_State;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] TY_DP = 4'd0, TY_LDST = 4'd2, TY_BR = 4'd3, TY_SWI = 4'd4;

  cpu_sequencer dut (
    .clock(clock), .nreset(nreset), .i_Stall(i_Stall),
    .i_Instruction(i_Instruction), .i_Instruction_type(i_Instruction_type),
    .i_Set_cond(i_Set_cond), .i_Byte(i_Byte), .i_Alu_CNZV(i_Alu_CNZV),
    .i_Alu_writeback(i_Alu_writeback), .i_Mem_addr(i_Mem_addr),
    .i_Branch_target(i_Branch_target), .o_Pc(o_Pc), .o_Instr_reg(o_Instr_reg),
    .o_CNZV(o_CNZV), .o_Ram_Addr(o_Ram_Addr), .o_Ram_Write_enable(o_Ram_Write_enable),
    .o_Ram_Size(o_Ram_Size), .o_Reg_write_enable(o_Reg_write_enable),
    .o_Wb_sel(o_Wb_sel), .o_Halted(o_Halted), .o_State(o_State)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_instr(input logic [31:0] ins, input logic [3:0] ty, input logic s);
    i_Instruction      = ins;
    i_Instruction_type = ty;
    i_Set_cond         = s;
  endtask

  // Unconditional branch used to place the PC before a scenario
  task automatic goto_pc(input logic [13:0] target);
    set_instr(32'hEA000000, TY_BR, 1'b0);
    i_Branch_target = target;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    tick();
    nreset = 1'b0;
    #1;
    checks++; if (o_Pc !== 14'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", o_Pc); end
    checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_State); end
    checks++; if ({o_Instr_reg, o_CNZV, o_Halted} !== {32'h0, 4'h0, 1'b0}) begin errors++;
      $display("FAIL reset_regs got ir=%h cnzv=%b halt=%b exp 0", o_Instr_reg, o_CNZV, o_Halted); end
    checks++; if ({o_Ram_Size, o_Ram_Write_enable, o_Reg_write_enable, o_Wb_sel, o_Ram_Addr} !== {2'b10, 1'b0, 1'b0, 2'd0, 14'h0}) begin
      errors++; $display("FAIL reset_outs got size=%b rwe=%b we=%b sel=%0d addr=%h", o_Ram_Size, o_Ram_Write_enable, o_Reg_write_enable, o_Wb_sel, o_Ram_Addr); end
  endtask

  // ADD with S, result zero: F,D,E,WB then PC=4
  task automatic test_dp();
    set_instr(32'hE0900000, TY_DP, 1'b1);
    i_Alu_CNZV = 4'b0010; i_Alu_writeback = 1'b1;
    checks++; if ({o_State, o_Ram_Addr} !== {3'd0, 14'h0000}) begin errors++; $display("FAIL dp_fetch got st=%0d addr=%h", o_State, o_Ram_Addr); end
    tick();
    checks++; if ({o_State, o_Ram_Addr} !== {3'd1, 14'h0000}) begin errors++; $display("FAIL dp_decode got st=%0d addr=%h", o_State, o_Ram_Addr); end
    tick();
    checks++; if ({o_State, o_Reg_write_enable, o_CNZV, o_Instr_reg} !== {3'd2, 1'b0, 4'b0000, 32'hE0900000}) begin errors++;
      $display("FAIL dp_execute got st=%0d we=%b cnzv=%b ir=%h", o_State, o_Reg_write_enable, o_CNZV, o_Instr_reg); end
    tick();
    checks++; if ({o_State, o_Reg_write_enable, o_Wb_sel, o_CNZV} !== {3'd4, 1'b1, 2'd0, 4'b0010}) begin errors++;
      $display("FAIL dp_writeback got st=%0d we=%b sel=%0d cnzv=%b", o_State, o_Reg_write_enable, o_Wb_sel, o_CNZV); end
    tick();
    checks++; if ({o_State, o_Pc, o_Reg_write_enable} !== {3'd0, 14'h0004, 1'b0}) begin errors++;
      $display("FAIL dp_done got st=%0d pc=%h we=%b exp st=0 pc=0004 we=0", o_State, o_Pc, o_Reg_write_enable); end
  endtask

  // LDR word from 0x0100 at PC 0x0010
  task automatic test_load();
    goto_pc(14'h0010);
    checks++; if (o_Pc !== 14'h0010) begin errors++; $display("FAIL ld_start_pc got=%h exp=0010", o_Pc); end
    set_instr(32'hE5900000, TY_LDST, 1'b1);
    i_Byte = 1'b0; i_Mem_addr = 14'h0100;
    tick(); tick(); tick();
    checks++; if ({o_State, o_Ram_Addr, o_Ram_Size, o_Ram_Write_enable, o_Reg_write_enable} !== {3'd3, 14'h0100, 2'b10, 1'b0, 1'b0}) begin errors++;
      $display("FAIL ld_memory got st=%0d addr=%h size=%b rwe=%b we=%b", o_State, o_Ram_Addr, o_Ram_Size, o_Ram_Write_enable, o_Reg_write_enable); end
    tick();
    checks++; if ({o_State, o_Ram_Addr, o_Reg_write_enable, o_Wb_sel, o_Ram_Write_enable} !== {3'd4, 14'h0100, 1'b1, 2'd1, 1'b0}) begin errors++;
      $display("FAIL ld_writeback got st=%0d addr=%h we=%b sel=%0d rwe=%b", o_State, o_Ram_Addr, o_Reg_write_enable, o_Wb_sel, o_Ram_Write_enable); end
    tick();
    checks++; if ({o_State, o_Pc} !== {3'd0, 14'h0014}) begin errors++; $display("FAIL ld_done got st=%0d pc=%h exp 0/0014", o_State, o_Pc); end
  endtask

  // STRB to 0x0203, stalled two cycles in MEMORY
  task automatic test_store_stall();
    set_instr(32'hE5C00000, TY_LDST, 1'b0);
    i_Byte = 1'b1; i_Mem_addr = 14'h0203;
    tick(); tick(); tick();
    i_Stall = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if ({o_State, o_Ram_Write_enable, o_Ram_Addr, o_Pc} !== {3'd3, 1'b0, 14'h0203, 14'h0014}) begin errors++;
        $display("FAIL st_stall%0d got st=%0d rwe=%b addr=%h pc=%h", k, o_State, o_Ram_Write_enable, o_Ram_Addr, o_Pc); end
      tick();
    end
    i_Stall = 1'b0;
    #1;
    checks++; if ({o_State, o_Ram_Write_enable, o_Ram_Size, o_Ram_Addr} !== {3'd3, 1'b1, 2'b00, 14'h0203}) begin errors++;
      $display("FAIL st_release got st=%0d rwe=%b size=%b addr=%h", o_State, o_Ram_Write_enable, o_Ram_Size, o_Ram_Addr); end
    tick();
    checks++; if ({o_State, o_Pc, o_Ram_Write_enable, o_Reg_write_enable} !== {3'd0, 14'h0018, 1'b0, 1'b0}) begin errors++;
      $display("FAIL st_done got st=%0d pc=%h rwe=%b we=%b", o_State, o_Pc, o_Ram_Write_enable, o_Reg_write_enable); end
    i_Byte = 1'b0;
  endtask

  // CMP clears Z, BEQ falls through, ADDS sets Z, BEQ taken, then BL
  task automatic test_branch();
    set_instr(32'hE1500000, TY_DP, 1'b1);
    i_Alu_CNZV = 4'b1000; i_Alu_writeback = 1'b0;
    tick(); tick(); tick();
    checks++; if ({o_State, o_Reg_write_enable, o_CNZV} !== {3'd4, 1'b0, 4'b1000}) begin errors++;
      $display("FAIL cmp_writeback got st=%0d we=%b cnzv=%b", o_State, o_Reg_write_enable, o_CNZV); end
    tick();
    checks++; if (o_Pc !== 14'h001C) begin errors++; $display("FAIL cmp_pc got=%h exp=001C", o_Pc); end
    set_instr(32'h0A000000, TY_BR, 1'b0);
    i_Branch_target = 14'h0043;
    tick(); tick();
    checks++; if ({o_State, o_Reg_write_enable, o_Ram_Write_enable} !== {3'd2, 1'b0, 1'b0}) begin errors++;
      $display("FAIL beq_nt_exec got st=%0d we=%b rwe=%b", o_State, o_Reg_write_enable, o_Ram_Write_enable); end
    tick();
    checks++; if ({o_State, o_Pc, o_CNZV} !== {3'd0, 14'h0020, 4'b1000}) begin errors++;
      $display("FAIL beq_nt_done got st=%0d pc=%h cnzv=%b", o_State, o_Pc, o_CNZV); end
    set_instr(32'hE0900000, TY_DP, 1'b1);
    i_Alu_CNZV = 4'b0010; i_Alu_writeback = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if ({o_Pc, o_CNZV} !== {14'h0024, 4'b0010}) begin errors++; $display("FAIL adds_z got pc=%h cnzv=%b", o_Pc, o_CNZV); end
    set_instr(32'h0A000000, TY_BR, 1'b0);
    tick(); tick(); tick();
    checks++; if ({o_State, o_Pc} !== {3'd0, 14'h0040}) begin errors++; $display("FAIL beq_taken got st=%0d pc=%h exp 0/0040", o_State, o_Pc); end
    set_instr(32'hEB000000, TY_BR, 1'b1);
    i_Branch_target = 14'h0100;
    tick(); tick();
    checks++; if ({o_State, o_Reg_write_enable, o_Wb_sel} !== {3'd2, 1'b1, 2'd2}) begin errors++;
      $display("FAIL bl_link got st=%0d we=%b sel=%0d exp 2/1/2", o_State, o_Reg_write_enable, o_Wb_sel); end
    tick();
    checks++; if ({o_State, o_Pc, o_Reg_write_enable} !== {3'd0, 14'h0100, 1'b0}) begin errors++;
      $display("FAIL bl_done got st=%0d pc=%h we=%b", o_State, o_Pc, o_Reg_write_enable); end
  endtask

  // Branch target 0x3FFE aligns to 0x3FFC; NOP there wraps PC to 0
  task automatic test_wrap();
    goto_pc(14'h3FFE);
    checks++; if (o_Pc !== 14'h3FFC) begin errors++; $display("FAIL wrap_align got=%h exp=3FFC", o_Pc); end
    set_instr(32'hE1A00000, TY_DP, 1'b0);
    i_Alu_CNZV = 4'b0101; i_Alu_writeback = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if ({o_State, o_Pc, o_CNZV} !== {3'd0, 14'h0000, 4'b0010}) begin errors++;
      $display("FAIL wrap_pc got st=%0d pc=%h cnzv=%b exp 0/0000/0010", o_State, o_Pc, o_CNZV); end
  endtask

  task automatic test_halt();
    set_instr(32'hEF000000, TY_SWI, 1'b0);
    tick(); tick(); tick();
    for (int k = 0; k < 20; k++) begin
      checks++; if ({o_Halted, o_State, o_Pc, o_Reg_write_enable, o_Ram_Write_enable} !== {1'b1, 3'd5, 14'h0000, 1'b0, 1'b0}) begin errors++;
        $display("FAIL halt_c%0d got halt=%b st=%0d pc=%h we=%b rwe=%b", k, o_Halted, o_State, o_Pc, o_Reg_write_enable, o_Ram_Write_enable); end
      tick();
    end
    nreset = 1'b1;
    tick();
    nreset = 1'b0;
    #1;
    checks++; if ({o_Halted, o_State, o_Pc} !== {1'b0, 3'd0, 14'h0000}) begin errors++;
      $display("FAIL halt_reset got halt=%b st=%0d pc=%h", o_Halted, o_State, o_Pc); end
  endtask

  // Reset arriving while a store sits in MEMORY must not strobe
  task automatic test_reset_store();
    set_instr(32'hE5800000, TY_LDST, 1'b0);
    i_Mem_addr = 14'h0203;
    tick(); tick(); tick();
    checks++; if ({o_State, o_Ram_Write_enable} !== {3'd3, 1'b1}) begin errors++;
      $display("FAIL rs_premem got st=%0d rwe=%b exp 3/1", o_State, o_Ram_Write_enable); end
    nreset = 1'b1;
    #1;
    checks++; if (o_Ram_Write_enable !== 1'b0) begin errors++; $display("FAIL rs_reset_cycle got rwe=%b exp=0", o_Ram_Write_enable); end
    tick();
    nreset = 1'b0;
    #1;
    checks++; if ({o_State, o_Pc, o_Ram_Write_enable} !== {3'd0, 14'h0000, 1'b0}) begin errors++;
      $display("FAIL rs_after got st=%0d pc=%h rwe=%b", o_State, o_Pc, o_Ram_Write_enable); end
  endtask

  initial begin
    nreset = 1'b1; i_Stall = 1'b0;
    i_Instruction = 32'h0; i_Instruction_type = TY_DP; i_Set_cond = 1'b0; i_Byte = 1'b0;
    i_Alu_CNZV = 4'b0000; i_Alu_writeback = 1'b0; i_Mem_addr = 14'h0; i_Branch_target = 14'h0;
    test_reset();
    test_dp();
    test_load();
    test_store_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
